// File: rtl/shift_reg_ser_to_par_rx.sv
// Serial-to-parallel receiver: frames latch bit order, WIDTH-bit words go out on a valid/ready port.
// Optional even-parity bit per word when SHIFT_REG_RX_PARITY_CHECK_EN is defined.
module shift_reg_ser_to_par_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             ser_in,
    input  logic             shift_en_in,
    input  logic             frame_start_in,
    input  logic             msb_first_in,
    input  logic             par_ready_in,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid_out,
    output logic             latched_msb_out,
    output logic             busy_out,
    output logic             overrun_out,
    output logic             parity_err_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SHIFT_REG_RX_PARITY_CHECK_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   par_q, par_d;
    logic               valid_q, valid_d;
    logic               msb_q, msb_d;
    logic               overrun_q, overrun_d;
    logic               perr_q, perr_d;

    logic [CNT_W-1:0]   cur_cnt;
    logic               cur_msb;
    logic               capture;
    logic [WIDTH-1:0]   shifted;
    logic               word_done;
    logic [WIDTH-1:0]   word;
    logic               word_perr;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            par_q     <= '0;
            valid_q   <= 1'b0;
            msb_q     <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            msb_q     <= msb_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        valid_d   = valid_q;
        msb_d     = msb_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        word_done = 1'b0;
        word_perr = 1'b0;

        // A frame start takes effect for a bit captured in the same cycle.
        cur_cnt = frame_start_in ? '0 : bit_cnt_q;
        cur_msb = frame_start_in ? msb_first_in : msb_q;
        capture = shift_en_in && (frame_start_in || (state_q == SHIFT));
        shifted = cur_msb ? {sreg_q[WIDTH-2:0], ser_in} : {ser_in, sreg_q[WIDTH-1:1]};
        word    = shifted;

        if (frame_start_in) begin
            state_d   = SHIFT;
            msb_d     = msb_first_in;
            bit_cnt_d = '0;
        end

        if (capture) begin
`ifdef SHIFT_REG_RX_PARITY_CHECK_EN
            if (cur_cnt == LAST_CNT) begin
                word_done = 1'b1;
                word      = sreg_q;
                word_perr = (^sreg_q) != ser_in;
                bit_cnt_d = '0;
            end else begin
                sreg_d    = shifted;
                bit_cnt_d = cur_cnt + CNT_W'(1);
            end
`else
            sreg_d = shifted;
            if (cur_cnt == LAST_CNT) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = cur_cnt + CNT_W'(1);
            end
`endif
        end

        // A completed word may replace the held one only if that one leaves this edge.
        if (word_done) begin
            if (!valid_q || par_ready_in) begin
                par_d   = word;
                valid_d = 1'b1;
                perr_d  = word_perr;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && par_ready_in) begin
            valid_d = 1'b0;
        end
    end

    assign par_out         = par_q;
    assign par_valid_out   = valid_q;
    assign latched_msb_out = msb_q;
    assign busy_out        = (state_q == SHIFT);
    assign overrun_out     = overrun_q;
    assign parity_err_out  = perr_q;

endmodule

// File: tb/tb_shift_reg_ser_to_par_rx.sv
// Bench for shift_reg_ser_to_par_rx: vector table, directed corner sequences and a random run
// checked against a bit-queue reference model.
module tb_shift_reg_ser_to_par_rx;

    localparam int W = 8;
`ifdef SHIFT_REG_RX_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = W + (PAR ? 1 : 0);

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         ser_in;
    logic         shift_en_in;
    logic         frame_start_in;
    logic         msb_first_in;
    logic         par_ready_in;
    logic [W-1:0] par_out;
    logic         par_valid_out;
    logic         latched_msb_out;
    logic         busy_out;
    logic         overrun_out;
    logic         parity_err_out;

    int errors = 0;
    int checks = 0;

    shift_reg_ser_to_par_rx #(.WIDTH(W)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .ser_in          (ser_in),
        .shift_en_in     (shift_en_in),
        .frame_start_in  (frame_start_in),
        .msb_first_in    (msb_first_in),
        .par_ready_in    (par_ready_in),
        .par_out         (par_out),
        .par_valid_out   (par_valid_out),
        .latched_msb_out (latched_msb_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out),
        .parity_err_out  (parity_err_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: captured bits of the current word kept as a queue.
    bit           m_shift;
    bit           m_msb;
    bit           m_bits[$];
    bit           m_valid;
    logic [W-1:0] m_word;
    bit           m_overrun;
    bit           m_perr;

    function automatic bit rbit();
        return 1'($urandom % 2);
    endfunction

    task automatic model_reset();
        m_shift = 0; m_msb = 0; m_bits.delete();
        m_valid = 0; m_word = '0; m_overrun = 0; m_perr = 0;
    endtask

    task automatic model_update(input bit fs, input bit msb, input bit ser, input bit en, input bit rdy);
        bit           done;
        bit           dx;
        logic [W-1:0] w;
        bit           pe;
        done = 0; w = '0; pe = 0;
        if (fs) begin
            m_shift = 1; m_msb = msb; m_bits.delete();
        end
        if (m_shift && en) begin
            m_bits.push_back(ser);
            if (m_bits.size() == NB) begin
                done = 1;
                for (int i = 0; i < W; i++) begin
                    if (m_msb) w = w | (W'(m_bits[i]) << (W - 1 - i));
                    else       w = w | (W'(m_bits[i]) << i);
                end
                if (PAR) begin
                    dx = 0;
                    for (int i = 0; i < W; i++) dx = dx ^ m_bits[i];
                    pe = (dx != m_bits[NB-1]);
                end
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word = w; m_valid = 1; m_perr = pe;
            end else begin
                m_overrun = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model par_out", 32'(par_out), 32'(m_word));
        check("model par_valid", 32'(par_valid_out), 32'(m_valid));
        check("model latched_msb", 32'(latched_msb_out), 32'(m_msb));
        check("model busy", 32'(busy_out), 32'(m_shift));
        check("model overrun", 32'(overrun_out), 32'(m_overrun));
        check("model parity_err", 32'(parity_err_out), 32'(m_perr));
    endtask

    task automatic step(input bit fs, input bit msb, input bit ser, input bit en, input bit rdy);
        frame_start_in = fs;
        msb_first_in   = msb;
        ser_in         = ser;
        shift_en_in    = en;
        par_ready_in   = rdy;
        @(posedge clk_in);
        model_update(fs, msb, ser, en, rdy);
        #1;
        check_model();
    endtask

    // Sends one word (plus parity bit when enabled); msb_first_in wiggles to show it is ignored mid-frame.
    task automatic send_word(input logic [W-1:0] w, input bit msb, input int max_gap,
                             input bit rdy, input bit rdy_last, input bit pflip);
        logic [W-1:0] wv;
        bit           b;
        int           gaps;
        wv = w;
        for (int i = 0; i < NB; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gaps; g++) step(0, rbit(), rbit(), 0, rdy);
            if (i == W) b = (^wv) ^ pflip;
            else        b = msb ? wv[W-1-i] : wv[i];
            step(0, rbit(), b, 1, (i == NB - 1) ? rdy_last : rdy);
        end
    endtask

    typedef struct {
        bit           fs, msb, ser, en, rdy;
        logic [W-1:0] e_par;
        bit           e_valid, e_busy, e_latched, e_overrun;
    } vec_t;

    vec_t tbl[$];

    task automatic add_row(input bit fs, input bit msb, input bit ser, input bit en, input bit rdy,
                           input logic [W-1:0] e_par, input bit e_valid);
        vec_t v;
        v.fs = fs; v.msb = msb; v.ser = ser; v.en = en; v.rdy = rdy;
        v.e_par = e_par; v.e_valid = e_valid;
        v.e_busy = 1; v.e_latched = 1; v.e_overrun = 0;
        tbl.push_back(v);
    endtask

    initial begin
        logic [W-1:0] a5;
        bit           last;
        a5 = 8'hA5;

        rst_n_in = 0; frame_start_in = 0; msb_first_in = 0; ser_in = 0;
        shift_en_in = 0; par_ready_in = 0;
        model_reset();
        #12;
        check("reset par_out", 32'(par_out), 32'h0);
        check("reset par_valid", 32'(par_valid_out), 32'h0);
        check("reset busy", 32'(busy_out), 32'h0);
        check("reset overrun", 32'(overrun_out), 32'h0);
        rst_n_in = 1;

        // MSB-first A5, ready high: valid for exactly one cycle.
        add_row(1, 1, 0, 0, 1, 8'h00, 0);
        for (int i = 0; i < W; i++) begin
            last = (i == W - 1) && !PAR;
            add_row(0, 1, a5[W-1-i], 1, 1, last ? 8'hA5 : 8'h00, last);
        end
        if (PAR) add_row(0, 1, 1'b0, 1, 1, 8'hA5, 1);
        add_row(0, 1, 0, 0, 1, 8'hA5, 0);
        add_row(0, 0, 1, 0, 1, 8'hA5, 0);
        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].fs, tbl[r].msb, tbl[r].ser, tbl[r].en, tbl[r].rdy);
            check("tbl par_out", 32'(par_out), 32'(tbl[r].e_par));
            check("tbl par_valid", 32'(par_valid_out), 32'(tbl[r].e_valid));
            check("tbl busy", 32'(busy_out), 32'(tbl[r].e_busy));
            check("tbl latched_msb", 32'(latched_msb_out), 32'(tbl[r].e_latched));
            check("tbl overrun", 32'(overrun_out), 32'(tbl[r].e_overrun));
        end

        // LSB-first with idle gaps.
        step(1, 0, 0, 0, 1);
        send_word(8'hA5, 0, 3, 1, 1, 0);
        check("lsb par_out", 32'(par_out), 32'hA5);
        check("lsb par_valid", 32'(par_valid_out), 32'h1);
        check("lsb latched_msb", 32'(latched_msb_out), 32'h0);

        // Realign after a 5-bit partial word.
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, rbit(), 1, 1);
        step(1, 1, 0, 0, 1);
        send_word(8'h3C, 1, 0, 1, 1, 0);
        check("realign par_out", 32'(par_out), 32'h3C);
        check("realign par_valid", 32'(par_valid_out), 32'h1);
        check("realign overrun", 32'(overrun_out), 32'h0);
        step(0, 1, 0, 0, 1);

        // Backpressure, overrun, then transfer coinciding with completion.
        send_word(8'h11, 1, 0, 0, 0, 0);
        check("bp first par_out", 32'(par_out), 32'h11);
        send_word(8'h22, 1, 0, 0, 0, 0);
        check("bp held par_out", 32'(par_out), 32'h11);
        check("bp overrun", 32'(overrun_out), 32'h1);
        send_word(8'h33, 1, 0, 0, 1, 0);
        check("bp reload par_out", 32'(par_out), 32'h33);
        check("bp reload valid", 32'(par_valid_out), 32'h1);
        step(0, 1, 0, 0, 1);

        // Parity good then bad (always 0 without the parity option).
        send_word(8'hA5, 1, 0, 1, 1, 0);
        check("parity good", 32'(parity_err_out), 32'h0);
        send_word(8'hA5, 1, 0, 1, 1, 1);
        check("parity bad", 32'(parity_err_out), PAR ? 32'h1 : 32'h0);
        step(0, 1, 0, 0, 1);

        // Reset mid-word with a pending word.
        send_word(8'h5A, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
        rst_n_in = 0;
        #2;
        model_reset();
        check("async rst par_out", 32'(par_out), 32'h0);
        check("async rst par_valid", 32'(par_valid_out), 32'h0);
        check("async rst busy", 32'(busy_out), 32'h0);
        check("async rst overrun", 32'(overrun_out), 32'h0);
        check("async rst parity_err", 32'(parity_err_out), 32'h0);
        check("async rst latched", 32'(latched_msb_out), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1;
        for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 0);
        check("idle ignores shift valid", 32'(par_valid_out), 32'h0);
        check("idle ignores shift busy", 32'(busy_out), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 40) == 0, rbit(), rbit(), ($urandom % 4) != 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
